vector_regfile: RTL and testbench

- Vector register file directly upstream of vectorial_alu; supplies its 128-bit A/B operands (rd1/rd2) and accepts ALU results on the write port.
- Holds NREGS registers of 4 x 32-bit lanes. Lane 0 is bits [31:0], lane 3 is bits [127:96].
- Supports scalar writes (lane 0 only), lane-masked vector writes, write-to-read bypass, and a sequenced post-reset clear with a ready flag.

---
 rtl/vec_pkg.sv | 29 ++
 rtl/vector_regfile_if.sv | 27 ++
 rtl/vector_regfile.sv | 84 ++++++++
 tb/tb_vector_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and the lane merge helper for the vector register file.
package vec_pkg;
   localparam int LANES  = 4;
   localparam int LANE_W = 32;
   localparam int VLEN   = 128;

   typedef logic [VLEN-1:0]  vword_t;
   typedef logic [LANES-1:0] lane_mask_t;

   typedef enum logic {
      INIT,
      RUN
   } rf_state_t;

   function automatic vword_t lane_merge(
      vword_t     old_w,
      vword_t     new_w,
      lane_mask_t mask
   );
      vword_t r;
      r = old_w;
      for (int i = 0; i < LANES; i++) begin
         if (mask[i]) begin
            r[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/vector_regfile_if.sv
// Read/write port bundle between the vector register file and its users.
interface vector_regfile_if #(
   parameter int AW = 4
);
   import vec_pkg::*;

   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   vword_t        rd1;
   vword_t        rd2;
   logic          we;
   logic [AW-1:0] wa;
   vword_t        wd;
   logic          vectorial;
   lane_mask_t    lane_mask;
   logic          ready;

   modport master (
      output ra1, ra2, we, wa, wd, vectorial, lane_mask,
      input  rd1, rd2, ready
   );

   modport slave (
      input  ra1, ra2, we, wa, wd, vectorial, lane_mask,
      output rd1, rd2, ready
   );
endinterface

// File: rtl/vector_regfile.sv
// 4-lane vector register file with masked writes, bypass and
// a sequenced post-reset clear.
module vector_regfile
   import vec_pkg::*;
#(
   parameter int NREGS    = 16,
   parameter int AW       = 4,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic              clk,
   input logic              rst,
   vector_regfile_if.slave  rf
);

   rf_state_t     state;
   logic [AW-1:0] clr_cnt;
   logic          ready_q;
   vword_t        mem [NREGS];

   lane_mask_t    wmask;
   vword_t        merged;
   logic          wr_ok;
   vword_t        rd1_c;
   vword_t        rd2_c;

   // Scalar writes only ever touch lane 0.
   assign wmask  = rf.vectorial ? rf.lane_mask : lane_mask_t'(1);
   assign merged = lane_merge(mem[rf.wa], rf.wd, wmask);
   assign wr_ok  = (state == RUN) && rf.we &&
                   !((ZERO_REG != 0) && (rf.wa == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT;
         clr_cnt <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               mem[clr_cnt] <= '0;
               clr_cnt      <= clr_cnt + 1'b1;
               if (clr_cnt == AW'(NREGS - 1)) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               if (wr_ok) begin
                  mem[rf.wa] <= merged;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   always_comb begin
      rd1_c = mem[rf.ra1];
      if ((BYPASS != 0) && wr_ok && (rf.ra1 == rf.wa)) begin
         rd1_c = merged;
      end
      if ((state != RUN) ||
          ((ZERO_REG != 0) && (rf.ra1 == '0))) begin
         rd1_c = '0;
      end
   end

   always_comb begin
      rd2_c = mem[rf.ra2];
      if ((BYPASS != 0) && wr_ok && (rf.ra2 == rf.wa)) begin
         rd2_c = merged;
      end
      if ((state != RUN) ||
          ((ZERO_REG != 0) && (rf.ra2 == '0))) begin
         rd2_c = '0;
      end
   end

   assign rf.rd1   = rd1_c;
   assign rf.rd2   = rd2_c;
   assign rf.ready = ready_q;

endmodule

// File: tb/tb_vector_regfile.sv
// Directed bench for vector_regfile: bypass and no-bypass instances
// checked every cycle against a behavioural model.
module tb_vector_regfile;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   vector_regfile_if #(.AW(4)) ifa ();
   vector_regfile_if #(.AW(4)) ifb ();

   assign ifb.ra1       = ifa.ra1;
   assign ifb.ra2       = ifa.ra2;
   assign ifb.we        = ifa.we;
   assign ifb.wa        = ifa.wa;
   assign ifb.wd        = ifa.wd;
   assign ifb.vectorial = ifa.vectorial;
   assign ifb.lane_mask = ifa.lane_mask;

   vector_regfile #(
      .NREGS(16), .AW(4), .BYPASS(1), .ZERO_REG(1)
   ) dut_a (
      .clk(clk), .rst(rst), .rf(ifa.slave)
   );

   vector_regfile #(
      .NREGS(16), .AW(4), .BYPASS(0), .ZERO_REG(1)
   ) dut_b (
      .clk(clk), .rst(rst), .rf(ifb.slave)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Model: contents, and how many clear edges have passed since reset.
   logic [127:0] m_mem [16];
   int           m_clr = 16;
   bit           m_rst_seen = 1'b0;

   function automatic logic [127:0] upd(logic [127:0] old_v);
      logic [127:0] v;
      v = old_v;
      for (int i = 0; i < 4; i++) begin
         if (ifa.vectorial ? ifa.lane_mask[i] : (i == 0)) begin
            v[i*32 +: 32] = ifa.wd[i*32 +: 32];
         end
      end
      return v;
   endfunction

   function automatic bit m_ready();
      return m_rst_seen && (m_clr >= 16);
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_clr      = 0;
         m_rst_seen = 1'b1;
      end else if (m_clr < 16) begin
         m_mem[m_clr] = '0;
         m_clr        = m_clr + 1;
      end else if (ifa.we && ifa.wa != 0) begin
         m_mem[ifa.wa] = upd(m_mem[ifa.wa]);
      end
   end

   function automatic logic [127:0] exp_rd(logic [3:0] ra, bit byp);
      if (!m_ready() || ra == 0) return '0;
      if (byp && ifa.we && ra == ifa.wa) return upd(m_mem[ra]);
      return m_mem[ra];
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_rd1_byp", ifa.rd1, exp_rd(ifa.ra1, 1'b1));
         chk("cyc_rd2_byp", ifa.rd2, exp_rd(ifa.ra2, 1'b1));
         chk("cyc_rd1_nob", ifb.rd1, exp_rd(ifa.ra1, 1'b0));
         chk("cyc_rd2_nob", ifb.rd2, exp_rd(ifa.ra2, 1'b0));
         chk("cyc_ready_a", 128'(ifa.ready), 128'(m_ready()));
         chk("cyc_ready_b", 128'(ifb.ready), 128'(m_ready()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(string nm);
      int n;
      n = 0;
      while (!ifa.ready && n < 40) begin
         step();
         n++;
      end
      chk(nm, 128'(n), 128'd16);
   endtask

   task automatic wr(logic [3:0] a, logic [127:0] d, bit vec,
                     logic [3:0] m);
      ifa.we        = 1'b1;
      ifa.wa        = a;
      ifa.wd        = d;
      ifa.vectorial = vec;
      ifa.lane_mask = m;
   endtask

   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] V1234 =
      128'h00000001_00000002_00000003_00000004;

   initial begin
      ifa.ra1 = '0; ifa.ra2 = '0; ifa.we = 1'b0; ifa.wa = '0;
      ifa.wd = '0; ifa.vectorial = 1'b0; ifa.lane_mask = '0;

      rst = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      ifa.ra1 = 4'd5;
      #1;
      chk("init_rd_zero", ifa.rd1, '0);
      wait_ready("first_clear_len");

      // Preload reg 5, then reset with a write to reg 3 held throughout.
      wr(4'd5, ONES, 1'b1, 4'hF);
      step();
      ifa.we = 1'b0;
      #1;
      chk("preload_r5", ifa.rd1, ONES);
      rst = 1'b1;
      wr(4'd3, ONES, 1'b1, 4'hF);
      step();
      step();
      rst = 1'b0;
      wait_ready("reset_clear_len");
      ifa.we = 1'b0;
      ifa.ra1 = 4'd5;
      ifa.ra2 = 4'd3;
      #1;
      chk("r5_cleared", ifa.rd1, '0);
      chk("r3_init_write_lost", ifa.rd2, '0);

      // Full, scalar and masked writes to reg 2.
      wr(4'd2, V1234, 1'b1, 4'hF);
      step();
      ifa.we = 1'b0;
      ifa.ra1 = 4'd2;
      #1;
      chk("full_vec", ifa.rd1, V1234);
      wr(4'd2, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_0000000A, 1'b0, 4'hF);
      step();
      ifa.we = 1'b0;
      #1;
      chk("scalar", ifa.rd1,
          128'h00000001_00000002_00000003_0000000A);
      wr(4'd2, ONES, 1'b1, 4'b0100);
      step();
      ifa.we = 1'b0;
      #1;
      chk("mask_0100", ifa.rd1,
          128'h00000001_FFFFFFFF_00000003_0000000A);
      wr(4'd2, ONES, 1'b1, 4'b0000);
      step();
      ifa.we = 1'b0;
      #1;
      chk("mask_0000", ifa.rd1,
          128'h00000001_FFFFFFFF_00000003_0000000A);

      // Same-cycle bypass on both ports of reg 4.
      ifa.ra1 = 4'd4;
      ifa.ra2 = 4'd4;
      wr(4'd4, {4{32'hAAAAAAAA}}, 1'b1, 4'b0011);
      #1;
      chk("byp_rd1", ifa.rd1,
          128'h00000000_00000000_AAAAAAAA_AAAAAAAA);
      chk("byp_rd2", ifa.rd2,
          128'h00000000_00000000_AAAAAAAA_AAAAAAAA);
      chk("nobyp_rd1", ifb.rd1, '0);
      step();
      ifa.we = 1'b0;
      #1;
      chk("nobyp_after", ifb.rd1,
          128'h00000000_00000000_AAAAAAAA_AAAAAAAA);

      // Register 0 is hardwired to zero.
      ifa.ra1 = 4'd0;
      wr(4'd0, ONES, 1'b1, 4'hF);
      #1;
      chk("zero_same_cyc", ifa.rd1, '0);
      step();
      ifa.we = 1'b0;
      #1;
      chk("zero_after", ifa.rd1, '0);

      // Mid-operation reset clears reg 7.
      wr(4'd7, {4{32'h12345678}}, 1'b1, 4'hF);
      step();
      ifa.we = 1'b0;
      ifa.ra1 = 4'd7;
      #1;
      chk("r7_loaded", ifa.rd1, {4{32'h12345678}});
      rst = 1'b1;
      step();
      chk("ready_drop", 128'(ifa.ready), '0);
      rst = 1'b0;
      wait_ready("mid_clear_len");
      #1;
      chk("r7_cleared", ifa.rd1, '0);

      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
